simplest4_parallel: RTL and testbench

//  Array of LANES independent 1-bit accumulator micro-processors sharing one program counter (SIMD).

---
 rtl/simplest4_parallel.sv | 87 ++++++++
 tb/tb_simplest4_parallel.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/simplest4_parallel.sv
// SIMD array of LANES 1-bit accumulator cores that share one 3-bit program counter; each lane has its own 8-word ROM.
// Optional macro SIMPLEST4_HALT_EN makes opcode 111 a HALT that freezes pc and every accumulator.
module simplest4_parallel #(
  parameter int LANES = 4,
  localparam int PAIRS = (LANES + 1) / 2,
  // Bits 31:0 hold the even-lane ROM and bits 63:32 hold the odd-lane ROM.
  // The two ROMs differ only in the LDI immediate at address 0.
  localparam logic [PAIRS*64-1:0] DEF_IMG = {PAIRS{64'hE09A4793_E09A4792}},
  parameter logic [LANES*32-1:0] PROGRAM = DEF_IMG[LANES*32-1:0]
) (
  input  logic             clk,
  input  logic             preset,
  input  logic             counter_ram8_reset,
  output logic [LANES-1:0] accumulator_output
);

  logic [2:0]       pc_q, pc_d;
  logic [LANES-1:0] acc_q, acc_d;
  logic [3:0]       word;
`ifdef SIMPLEST4_HALT_EN
  logic             halted_q, halted_d;
  logic             halt_hit;
`endif

  function automatic logic exec_op(input logic [3:0] w, input logic a);
    logic r;
    r = a;
    case (w[3:1])
      3'b001:  r = w[0];
      3'b010:  r = a & w[0];
      3'b011:  r = a | w[0];
      3'b100:  r = a ^ w[0];
      3'b101:  r = ~a;
      default: r = a;
    endcase
    return r;
  endfunction

  always_comb begin
    pc_d  = pc_q + 3'd1;
    acc_d = acc_q;
    word  = 4'd0;
`ifdef SIMPLEST4_HALT_EN
    halted_d = halted_q;
    halt_hit = 1'b0;
`endif
    for (int l = 0; l < LANES; l++) begin
      word     = PROGRAM[l*32 + int'(pc_q)*4 +: 4];
      acc_d[l] = exec_op(word, acc_q[l]);
`ifdef SIMPLEST4_HALT_EN
      if (word[3:1] == 3'b111) halt_hit = 1'b1;
`endif
    end
`ifdef SIMPLEST4_HALT_EN
    // A HALT in any lane freezes the whole array at the halting address.
    if (halted_q || halt_hit) begin
      pc_d     = pc_q;
      acc_d    = acc_q;
      halted_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (preset) begin
      pc_q  <= 3'd0;
      acc_q <= '0;
`ifdef SIMPLEST4_HALT_EN
      halted_q <= 1'b0;
`endif
    end else if (counter_ram8_reset) begin
      pc_q <= 3'd0;
`ifdef SIMPLEST4_HALT_EN
      halted_q <= 1'b0;
`endif
    end else begin
      pc_q  <= pc_d;
      acc_q <= acc_d;
`ifdef SIMPLEST4_HALT_EN
      halted_q <= halted_d;
`endif
    end
  end

  assign accumulator_output = acc_q;

endmodule

// File: tb/tb_simplest4_parallel.sv
// Scoreboard bench for simplest4_parallel: default-program instance plus a lane0 toggle-program instance.
module tb_simplest4_parallel;

  logic       clk = 1'b0;
  logic       preset = 1'b1;
  logic       counter_ram8_reset = 1'b0;
  logic [3:0] acc_d0;
  logic [3:0] acc_c;

  localparam logic [127:0] PROG_DEF = 128'hE09A4793_E09A4792_E09A4793_E09A4792;
  localparam logic [127:0] PROG_TOG = {96'h0, 32'hAAAAAAA3};

  always #5 clk = ~clk;

  simplest4_parallel #(.LANES(4)) dut (
    .clk(clk), .preset(preset), .counter_ram8_reset(counter_ram8_reset),
    .accumulator_output(acc_d0));

  simplest4_parallel #(.LANES(4), .PROGRAM(PROG_TOG)) dut_tog (
    .clk(clk), .preset(preset), .counter_ram8_reset(counter_ram8_reset),
    .accumulator_output(acc_c));

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] prog   [2];
  logic [2:0]   m_pc   [2];
  logic [3:0]   m_acc  [2];
  logic         m_halt [2];
  logic [3:0]   q0[$];
  logic [3:0]   q1[$];
  logic [3:0]   exp1 [5] = '{4'b1010, 4'b0101, 4'b1111, 4'b0000, 4'b1111};

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  function automatic void mdl(input int d, input logic pr, input logic cr);
    logic [3:0] w;
    logic [3:0] nacc;
    logic       hit;
    if (pr) begin
      m_pc[d] = 3'd0; m_acc[d] = 4'd0; m_halt[d] = 1'b0;
      return;
    end
    if (cr) begin
      m_pc[d] = 3'd0; m_halt[d] = 1'b0;
      return;
    end
    if (m_halt[d]) return;
    hit  = 1'b0;
    nacc = m_acc[d];
    for (int l = 0; l < 4; l++) begin
      w = prog[d][(l*8 + int'(m_pc[d]))*4 +: 4];
      case (w[3:1])
        3'b001: nacc[l] = w[0];
        3'b010: nacc[l] = nacc[l] & w[0];
        3'b011: nacc[l] = nacc[l] | w[0];
        3'b100: nacc[l] = nacc[l] ^ w[0];
        3'b101: nacc[l] = ~nacc[l];
`ifdef SIMPLEST4_HALT_EN
        3'b111: hit = 1'b1;
`endif
        default: ;
      endcase
    end
    if (hit) m_halt[d] = 1'b1;
    else begin
      m_acc[d] = nacc;
      m_pc[d]  = m_pc[d] + 3'd1;
    end
  endfunction

  // Drive one cycle, push model expectations, then pop and compare after the edge.
  task automatic step(input logic pr, input logic cr);
    preset = pr;
    counter_ram8_reset = cr;
    mdl(0, pr, cr);
    mdl(1, pr, cr);
    q0.push_back(m_acc[0]);
    q1.push_back(m_acc[1]);
    @(posedge clk);
    #1;
    chk("sb_default", acc_d0, q0.pop_front());
    chk("sb_toggle", acc_c, q1.pop_front());
  endtask

  initial begin
    prog[0] = PROG_DEF;
    prog[1] = PROG_TOG;
    for (int d = 0; d < 2; d++) begin
      m_pc[d] = 3'd0; m_acc[d] = 4'd0; m_halt[d] = 1'b0;
    end

    // Reset state and first trace
    step(1'b1, 1'b0);
    chk("reset_out", acc_d0, 4'b0000);
    chk("reset_tog", acc_c, 4'b0000);
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 1'b0);
      if (k <= 5) chk($sformatf("trace_c%0d", k), acc_d0, exp1[k-1]);
      chk($sformatf("tog_c%0d", k), acc_c, (k % 2 == 1) ? 4'b0001 : 4'b0000);
`ifdef SIMPLEST4_HALT_EN
      if (k >= 8) chk($sformatf("halt_hold_c%0d", k), acc_d0, 4'b0000);
`else
      if (k % 8 >= 1 && k % 8 <= 5 && k > 8)
        chk($sformatf("wrap_c%0d", k), acc_d0, exp1[(k % 8) - 1]);
`endif
    end

    // counter_ram8_reset restarts the program without touching acc (also clears a halt)
    step(1'b0, 1'b1);
    chk("crst_hold", acc_d0, 4'b0000);
    step(1'b0, 1'b0);
    chk("crst_addr0", acc_d0, 4'b1010);

    // Pulse after cycle 4 of a fresh run
    step(1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) step(1'b0, 1'b0);
    chk("pre_pulse", acc_d0, 4'b0000);
    step(1'b0, 1'b1);
    chk("pulse_hold", acc_d0, 4'b0000);
    step(1'b0, 1'b0);
    chk("pulse_addr0", acc_d0, 4'b1010);
    step(1'b0, 1'b0);
    chk("pulse_addr1", acc_d0, 4'b0101);

    // Pulse while acc is nonzero: acc must survive the pulse
    step(1'b0, 1'b0);
    chk("nz_before", acc_d0, 4'b1111);
    step(1'b0, 1'b1);
    chk("nz_hold", acc_d0, 4'b1111);

    // preset and counter_ram8_reset together mid-run
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    chk("both_reset", acc_d0, 4'b0000);
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 1'b0);
      chk($sformatf("after_both_c%0d", k), acc_d0, exp1[k-1]);
    end

    // Random control stimulus against the model
    for (int k = 0; k < 60; k++)
      step(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
